// File: rtl/cpu_datapath.sv
// Single-bus 32-bit datapath: 16-entry register file, PC/IR/MAR/MDR, Y/Z/HI/LO
// and a combinational ALU, all sequenced by one-hot strobes from outside.
module cpu_datapath (
  input  logic        clock,
  input  logic        clear,
  input  logic        IncPC,
  input  logic        R0out,
  input  logic        R1out,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        R4out,
  input  logic        R5out,
  input  logic        R6out,
  input  logic        R7out,
  input  logic        R8out,
  input  logic        R9out,
  input  logic        R10out,
  input  logic        R11out,
  input  logic        R12out,
  input  logic        R13out,
  input  logic        R14out,
  input  logic        R15out,
  input  logic        R0in,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        R4in,
  input  logic        R5in,
  input  logic        R6in,
  input  logic        R7in,
  input  logic        R8in,
  input  logic        R9in,
  input  logic        R10in,
  input  logic        R11in,
  input  logic        R12in,
  input  logic        R13in,
  input  logic        R14in,
  input  logic        R15in,
  input  logic        MARin,
  input  logic        MDRout,
  input  logic        MDRin,
  input  logic        memRead,
  input  logic [31:0] mDataIn,
  output logic [31:0] mDataOut,
  input  logic        PCout,
  input  logic        Zin,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        Yin,
  input  logic        IRin
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic [15:0] rout;
  logic [15:0] rin;

  logic [31:0] rf_q [16];
  logic [31:0] rf_d [16];
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] y_q, y_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] z_q, z_d;

  logic [31:0] bus;
  logic [63:0] alu_z;
  logic        unused_bits;

  assign rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                 R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                 R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

  // Ra/Rb fields and MAR are consumed by the future control unit and memory.
  assign unused_bits = ^{ir_q[26:0], mar_q};
  assign mDataOut    = mdr_q;

  function automatic logic [63:0] alu_f(input logic [4:0]  op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic signed [32:0] da, db, dq, dr;
    logic signed [31:0] as32;
    logic        [63:0] aa, rot_r, rot_l;
    logic        [4:0]  sh;
    sa    = {{32{a[31]}}, a};
    sb    = {{32{b[31]}}, b};
    as32  = a;
    sh    = b[4:0];
    aa    = {a, a};
    rot_r = aa >> sh;
    rot_l = aa << sh;
    // 33-bit operands keep MIN/-1 from overflowing the signed divider.
    da    = {a[31], a};
    db    = {b[31], b};
    dq    = '0;
    dr    = '0;
    if (b != 32'd0) begin
      dq = da / db;
      dr = da % db;
    end
    alu_f = {32'h0, b};
    case (op)
      OP_ADD:  alu_f = sa + sb;
      OP_SUB:  alu_f = sa - sb;
      OP_AND:  alu_f = {32'h0, a & b};
      OP_OR:   alu_f = {32'h0, a | b};
      OP_ROR:  alu_f = {32'h0, rot_r[31:0]};
      OP_ROL:  alu_f = {32'h0, rot_l[63:32]};
      OP_SHR:  alu_f = {32'h0, a >> sh};
      OP_SHRA: alu_f = {32'h0, 32'(as32 >>> sh)};
      OP_SHL:  alu_f = {32'h0, a << sh};
      OP_MUL:  alu_f = sa * sb;
      OP_DIV:  alu_f = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {dr[31:0], dq[31:0]};
      OP_NEG:  alu_f = -sb;
      OP_NOT:  alu_f = ~sb;
      default: alu_f = {32'h0, b};
    endcase
  endfunction

  // Bus mux: later assignments override earlier ones, so R0 ends up highest.
  always_comb begin
    bus = '0;
    if (MDRout)   bus = mdr_q;
    if (PCout)    bus = pc_q;
    if (Zlowout)  bus = z_q[31:0];
    if (Zhighout) bus = z_q[63:32];
    if (LOout)    bus = lo_q;
    if (HIout)    bus = hi_q;
    for (int i = 15; i >= 0; i--) begin
      if (rout[i]) bus = rf_q[i];
    end
  end

  assign alu_z = alu_f(ir_q[31:27], y_q, bus);

  always_comb begin
    pc_d  = IncPC ? pc_q + 32'd1 : pc_q;
    ir_d  = IRin  ? bus : ir_q;
    mar_d = MARin ? bus : mar_q;
    mdr_d = mdr_q;
    if (MDRin) mdr_d = memRead ? mDataIn : bus;
    y_d   = Yin   ? bus : y_q;
    hi_d  = HIin  ? bus : hi_q;
    lo_d  = LOin  ? bus : lo_q;
    z_d   = Zin   ? alu_z : z_q;
    for (int i = 0; i < 16; i++) begin
      rf_d[i] = rin[i] ? bus : rf_q[i];
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      z_q   <= '0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      z_q   <= z_d;
      for (int i = 0; i < 16; i++) rf_q[i] <= rf_d[i];
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: directed microstep sequences plus randomized ALU ops,
// observed by routing registers through MDR to mDataOut.
module tb_cpu_datapath;

  localparam int SRC_HI = 16, SRC_LO = 17, SRC_ZH = 18, SRC_ZL = 19, SRC_PC = 20, SRC_MDR = 21;

  logic        clock = 1'b0;
  logic        clear;
  logic        IncPC, MARin, MDRout, MDRin, memRead, PCout, Zin, Zhighout, Zlowout;
  logic        HIin, LOin, HIout, LOout, Yin, IRin;
  logic [15:0] rout, rin;
  logic [31:0] mDataIn, mDataOut;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_mdr, m_y, m_hi, m_lo;
  logic [63:0] m_z;

  always #5 clock = ~clock;

  cpu_datapath dut (
    .clock(clock), .clear(clear), .IncPC(IncPC),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .MARin(MARin), .MDRout(MDRout), .MDRin(MDRin), .memRead(memRead),
    .mDataIn(mDataIn), .mDataOut(mDataOut), .PCout(PCout), .Zin(Zin),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin),
    .HIout(HIout), .LOout(LOout), .Yin(Yin), .IRin(IRin)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Reference ALU: built bit-by-bit and with 64-bit integer arithmetic.
  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] t;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    t  = a;
    case (op)
      5'd3:  return 64'(sa + sb);
      5'd4:  return 64'(sa - sb);
      5'd5:  return {32'h0, a & b};
      5'd6:  return {32'h0, a | b};
      5'd7:  begin for (int i = 0; i < sh; i++) t = {t[0], t[31:1]};    return {32'h0, t}; end
      5'd8:  begin for (int i = 0; i < sh; i++) t = {t[30:0], t[31]};   return {32'h0, t}; end
      5'd9:  begin for (int i = 0; i < sh; i++) t = {1'b0, t[31:1]};    return {32'h0, t}; end
      5'd10: begin for (int i = 0; i < sh; i++) t = {t[31], t[31:1]};   return {32'h0, t}; end
      5'd11: begin for (int i = 0; i < sh; i++) t = {t[30:0], 1'b0};    return {32'h0, t}; end
      5'd15: return 64'(sa * sb);
      5'd16: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      5'd17: return 64'(-sb);
      5'd18: return 64'(~sb);
      default: return {32'h0, b};
    endcase
  endfunction

  task automatic clr();
    IncPC = 0; MARin = 0; MDRout = 0; MDRin = 0; memRead = 0; PCout = 0; Zin = 0;
    Zhighout = 0; Zlowout = 0; HIin = 0; LOin = 0; HIout = 0; LOout = 0; Yin = 0; IRin = 0;
    rout = '0; rin = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    clr();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_pc = '0; m_ir = '0; m_mdr = '0; m_y = '0; m_hi = '0; m_lo = '0; m_z = '0;
  endtask

  task automatic set_out(input int src);
    case (src)
      SRC_HI:  HIout = 1;
      SRC_LO:  LOout = 1;
      SRC_ZH:  Zhighout = 1;
      SRC_ZL:  Zlowout = 1;
      SRC_PC:  PCout = 1;
      SRC_MDR: MDRout = 1;
      default: rout[src] = 1;
    endcase
  endtask

  task automatic peek(input string tag, input int src, input logic [31:0] exp);
    set_out(src);
    MDRin = 1;
    memRead = 0;
    tick();
    check(tag, mDataOut, exp);
    m_mdr = exp;
  endtask

  task automatic load_reg(input int n, input logic [31:0] v);
    mDataIn = v; memRead = 1; MDRin = 1;
    tick();
    MDRout = 1; rin[n] = 1;
    tick();
    m_mdr = v; m_r[n] = v;
  endtask

  task automatic set_ir(input logic [4:0] op);
    mDataIn = {op, 27'h0}; memRead = 1; MDRin = 1;
    tick();
    MDRout = 1; IRin = 1;
    tick();
    m_mdr = {op, 27'h0}; m_ir = m_mdr;
  endtask

  task automatic alu_seq(input int ra, input int rb);
    rout[ra] = 1; Yin = 1;
    tick();
    m_y = m_r[ra];
    rout[rb] = 1; Zin = 1;
    tick();
    m_z = ref_alu(m_ir[31:27], m_y, m_r[rb]);
    Zlowout = 1; LOin = 1;
    tick();
    Zhighout = 1; HIin = 1;
    tick();
    m_lo = m_z[31:0]; m_hi = m_z[63:32];
  endtask

  task automatic alu_op(input logic [4:0] op, input int ra, input int rb);
    set_ir(op);
    alu_seq(ra, rb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0]  ops [14];
    logic [4:0]  op;
    logic [31:0] a, b;
    int          ra, rb;
    ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18, 5'd20};

    clr();
    mDataIn = '0;
    clear = 0;
    model_reset();
    repeat (2) @(negedge clock);
    check("reset_mdata", mDataOut, 32'h0);
    clear = 1;
    @(negedge clock);

    // Fetch: T0..T2
    PCout = 1; MARin = 1; IncPC = 1;
    tick();
    m_pc = 32'd1;
    peek("pc_after_inc", SRC_PC, 32'd1);
    mDataIn = 32'h8228_0000; memRead = 1; MDRin = 1;
    tick();
    check("mdr_fetch", mDataOut, 32'h8228_0000);
    m_mdr = 32'h8228_0000;
    MDRout = 1; IRin = 1;
    tick();
    m_ir = 32'h8228_0000;

    load_reg(4, 32'hFFFF_FFEB);
    load_reg(5, 32'd6);
    peek("r4_load", 4, 32'hFFFF_FFEB);
    peek("r5_load", 5, 32'd6);
    alu_seq(4, 5);
    peek("div_lo", SRC_LO, 32'hFFFF_FFFD);
    peek("div_hi", SRC_HI, 32'hFFFF_FFFD);

    load_reg(1, 32'h7FFF_FFFF);
    load_reg(2, 32'd2);
    alu_op(5'd15, 1, 2);
    peek("mul_ovf_lo", SRC_LO, 32'hFFFF_FFFE);
    peek("mul_ovf_hi", SRC_HI, 32'h0);
    load_reg(1, 32'hFFFF_FFFD);
    load_reg(2, 32'd5);
    alu_op(5'd15, 1, 2);
    peek("mul_neg_lo", SRC_LO, 32'hFFFF_FFF1);
    peek("mul_neg_hi", SRC_HI, 32'hFFFF_FFFF);
    load_reg(1, 32'd7);
    load_reg(2, 32'd0);
    alu_op(5'd16, 1, 2);
    peek("div0_lo", SRC_LO, 32'hFFFF_FFFF);
    peek("div0_hi", SRC_HI, 32'd7);
    peek("div0_zh", SRC_ZH, 32'd7);

    load_reg(1, 32'h8000_0001);
    load_reg(2, 32'd1);
    load_reg(3, 32'hF);
    alu_op(5'd7,  1, 2); peek("ror", SRC_LO, 32'hC000_0000);
    alu_op(5'd10, 1, 2); peek("shra", SRC_LO, 32'hC000_0000);
    alu_op(5'd9,  1, 2); peek("shr", SRC_LO, 32'h4000_0000);
    alu_op(5'd11, 1, 2); peek("shl", SRC_LO, 32'h0000_0002);
    alu_op(5'd8,  1, 2); peek("rol", SRC_LO, 32'h0000_0003);
    alu_op(5'd5,  1, 3); peek("and", SRC_LO, 32'h0000_0001);

    // Bus priority and the empty bus
    rout[3] = 1; LOout = 1; MDRin = 1;
    tick();
    check("prio_r3_over_lo", mDataOut, 32'hF);
    HIout = 1; Zlowout = 1; MDRin = 1;
    tick();
    check("prio_hi_over_zl", mDataOut, m_hi);
    MDRin = 1;
    tick();
    check("empty_bus", mDataOut, 32'h0);

    // Several in-strobes in one cycle
    mDataIn = 32'h1234_5678; memRead = 1; MDRin = 1;
    tick();
    MDRout = 1; rin[6] = 1; rin[7] = 1; Yin = 1;
    tick();
    m_r[6] = 32'h1234_5678; m_r[7] = 32'h1234_5678; m_y = 32'h1234_5678; m_mdr = m_r[6];
    peek("multi_in_r6", 6, 32'h1234_5678);
    peek("multi_in_r7", 7, 32'h1234_5678);

    // Async reset in the middle of T4
    load_reg(4, 32'hFFFF_FFEB);
    load_reg(5, 32'd6);
    set_ir(5'd16);
    rout[4] = 1; Yin = 1;
    tick();
    rout[5] = 1; Zin = 1;
    #2 clear = 0;
    #1 check("async_mdata", mDataOut, 32'h0);
    @(posedge clock);
    @(negedge clock);
    clr();
    clear = 1;
    model_reset();
    @(negedge clock);
    peek("rst_r4", 4, 32'h0);
    peek("rst_r5", 5, 32'h0);
    peek("rst_hi", SRC_HI, 32'h0);
    peek("rst_lo", SRC_LO, 32'h0);
    peek("rst_zl", SRC_ZL, 32'h0);
    peek("rst_zh", SRC_ZH, 32'h0);
    peek("rst_pc", SRC_PC, 32'h0);
    load_reg(4, 32'd5);
    set_ir(5'd3);
    rout[4] = 1; Zin = 1;
    tick();
    peek("rst_y_via_add", SRC_ZL, 32'd5);

    // Randomized ALU operations against the reference model
    for (int it = 0; it < 60; it++) begin
      op = ops[$urandom_range(0, 13)];
      ra = $urandom_range(0, 7);
      rb = $urandom_range(8, 15);
      a  = $urandom;
      b  = $urandom;
      if (op == 5'd3 || op == 5'd4) begin
        a = {{2{a[29]}}, a[29:0]};
        b = {{2{b[29]}}, b[29:0]};
      end
      if (op == 5'd16 && $urandom_range(0, 5) == 0) b = 32'd0;
      load_reg(ra, a);
      load_reg(rb, b);
      alu_op(op, ra, rb);
      peek($sformatf("rnd%0d_op%0d_lo", it, op), SRC_LO, m_lo);
      if (!(op inside {5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd17, 5'd18}))
        peek($sformatf("rnd%0d_op%0d_hi", it, op), SRC_HI, m_hi);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

Phase-1 single-bus 32-bit datapath. It holds the register file, the PC, IR, MAR and MDR, and the Y, Z, HI and LO registers, plus a combinational ALU. All transfers are driven by externally supplied one-hot control strobes, one microstep per clock. The block sits under the future control unit; for now a bench sequences the strobes directly.

## Interface
Parameters: none (data width fixed at 32 bits; register count fixed at 16).

Ports:
- clock  in  1  sole clock; all registers load on the rising edge.
- clear  in  1  asynchronous, active-low reset; clears every register.
- IncPC  in  1  PC <= PC+1 at the edge.
- R0out..R15out  in  1 each  drive Rn onto the bus.
- R0in..R15in  in  1 each  load Rn from the bus.
- MARin  in  1  load MAR from the bus.
- MDRout  in  1  drive MDR onto the bus.
- MDRin  in  1  load MDR (source selected by memRead).
- memRead  in  1  MDR source select: 1 = mDataIn, 0 = bus.
- mDataIn  in  32  memory read data.
- mDataOut  out  32  continuously equals MDR.
- PCout  in  1  drive PC onto the bus.
- Zin  in  1  load 64-bit Z from the ALU.
- Zhighout / Zlowout  in  1  drive Z[63:32] / Z[31:0] onto the bus.
- HIin / LOin  in  1  load HI / LO from the bus.
- HIout / LOout  in  1  drive HI / LO onto the bus.
- Yin  in  1  load Y from the bus.
- IRin  in  1  load IR from the bus.

## Operation
- Bus: 32-bit combinational mux with a fixed priority. If no out-strobe is asserted, the bus is 0.
- Bus priority, highest first: R0..R15, HI, LO, Zhigh, Zlow, PC, MDR.
- Every in-strobe loads the current bus value at the edge. Multiple in-strobes in one cycle are all legal.
- MDR loads only when MDRin is high; memRead chooses its source.
- R0 is an ordinary register in this phase.
- ALU operands: A = Y, B = bus. The opcode is IR[31:27]. Z is written only on Zin.
- Opcode map:
  - 00011 ADD: Z = sign-extended A+B.
  - 00100 SUB: Z = sign-extended A-B.
  - 00101 AND, 00110 OR: Z[31:0] = A op B, Z[63:32] = 0.
  - 00111 ROR, 01000 ROL: rotate A by B[4:0].
  - 01001 SHR (logical), 01010 SHRA (arithmetic), 01011 SHL: shift A by B[4:0].
  - 01111 MUL: signed 32x32, full 64-bit product in Z.
  - 10000 DIV: signed, truncating toward zero. Z[31:0] = quotient, Z[63:32] = remainder; the remainder takes the sign of the dividend.
  - 10001 NEG: Z = -B.
  - 10010 NOT: Z = ~B.
  - Any other opcode: Z[31:0] = B, Z[63:32] = 0.
- Divide by zero: quotient = 0xFFFFFFFF, remainder = A. No trap.
- IR[26:23] and IR[22:19] are register fields (Ra, Rb) reserved for the control unit. This block does not decode them.
- Rn is selected only by its explicit strobes.

## Timing
- Reset: clear low immediately zeroes R0-R15, PC, IR, MAR, MDR, Y, Z, HI and LO, so mDataOut = 0. Registers hold at 0 while clear stays low.
- Reset asserted mid-sequence aborts the operation; no partial state is retained.
- Loads take effect at the rising edge where the strobe is high. The new value is visible on the bus in the next cycle.
- The ALU and bus are combinational, so a multi-cycle op is one Zin cycle after Y is loaded.
- MUL and DIV complete in one cycle.
- Typical two-operand sequence:
  - T0: PCout, MARin, IncPC.
  - T1: memRead, MDRin.
  - T2: MDRout, IRin.
  - T3: Raout, Yin.
  - T4: Rbout, Zin.
  - T5: Zlowout, LOin (or Rzin).
  - T6: Zhighout, HIin.
- T0 simultaneity: MAR receives the old PC. PC increments the same edge.
- IncPC together with a PC bus load is not supported; IncPC wins.

## Test plan
- Reset and fetch:
  - Release clear, then pulse PCout+MARin+IncPC -> MAR = 0, PC = 1.
  - memRead+MDRin with mDataIn = 0x82280000 -> mDataOut = 0x82280000.
  - MDRout+IRin -> IR = 0x82280000.
- Register load: mDataIn = -21 into MDR, then MDRout+R4in -> R4 = 0xFFFFFFEB. Same path with 6 -> R5 = 6.
- DIV R4,R5 (IR = 0x82280000, opcode 10000): R4out+Yin, R5out+Zin, Zlowout+LOin, Zhighout+HIin -> LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFD (-3).
- MUL and divide-by-zero:
  - MUL 0x7FFFFFFF x 2 -> HI = 0, LO = 0xFFFFFFFE.
  - MUL -3 x 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
  - DIV 7/0 -> LO = 0xFFFFFFFF, HI = 7.
- Shifts and logic with Y = 0x80000001, bus = 1:
  - ROR -> 0xC0000000.
  - SHRA -> 0xC0000000.
  - SHR -> 0x40000000.
  - SHL -> 0x00000002.
  - AND with 0xF -> 0x1.
- Async reset mid-sequence: drive clear low between clock edges during T4 -> all registers and mDataOut read 0 before the next edge.
